// File: rtl/weight_fetch_pkg.sv
// -----------------------------------------------------------------------------
// weight_fetch_pkg
// Shared definitions for the weight fetch sequencer:
//   fsm_state_e    - sequencer states (IDLE, FETCH, DRAIN)
//   BYTES_PER_WORD - bytes carried by one SRAM / stream word
//   keep_mask()    - byte-valid mask for the final word of a kernel
// -----------------------------------------------------------------------------
package weight_fetch_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fsm_state_e;

   // rem is num_bytes modulo 4; a remainder of zero means the last word is full.
   function automatic logic [3:0] keep_mask(input logic [1:0] rem);
      keep_mask = (rem == 2'd0) ? 4'hF : 4'((5'd1 << rem) - 5'd1);
   endfunction

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl_if
// Bundles every non-clock/reset signal of weight_fetch_ctrl:
//   command  : start, base_addr, num_bytes -> busy, done
//   host     : host_wen, host_addr, host_d -> host_ready
//   sram     : sram_wen, sram_addr, sram_d -> weight_sram, sram_q <- weight_sram
//   stream   : out_valid, out_data, out_keep, out_last -> datapath, out_ready <-
// slave  : the view taken by weight_fetch_ctrl
// master : the view taken by the surrounding system (host, SRAM, datapath)
// -----------------------------------------------------------------------------
interface weight_fetch_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 17
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  num_bytes;
   logic              busy;
   logic              done;

   logic              host_wen;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_d;
   logic              host_ready;

   logic              sram_wen;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_keep;
   logic              out_last;

   modport slave (
      input  start, base_addr, num_bytes, host_wen, host_addr, host_d, sram_q, out_ready,
      output busy, done, host_ready, sram_wen, sram_addr, sram_d,
             out_valid, out_data, out_keep, out_last
   );

   modport master (
      output start, base_addr, num_bytes, host_wen, host_addr, host_d, sram_q, out_ready,
      input  busy, done, host_ready, sram_wen, sram_addr, sram_d,
             out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/weight_skid_fifo.sv
// -----------------------------------------------------------------------------
// weight_skid_fifo
// Two-entry synchronous FIFO with an empty-bypass path: when empty, an
// incoming entry is visible on deq_data in the same cycle it arrives, and is
// only stored if it is not consumed in that cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enq_vld, enq_data write side (no ready: the producer honours count)
//   deq_vld, deq_data read side head
//   deq_rdy           consumer accepts head
//   count             number of stored entries (excludes a bypassing entry)
// -----------------------------------------------------------------------------
module weight_skid_fifo #(
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enq_vld,
   input  logic [WIDTH-1:0] enq_data,
   output logic             deq_vld,
   output logic [WIDTH-1:0] deq_data,
   input  logic             deq_rdy,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_idx_q;
   logic             rd_idx_q;
   logic [1:0]       cnt_q;
   logic             empty;
   logic             store;
   logic             pop;

   assign empty    = (cnt_q == 2'd0);
   assign deq_vld  = ~empty | enq_vld;
   // Idle head reads as zero so the stream outputs are quiet when nothing is valid.
   assign deq_data = !empty ? mem_q[rd_idx_q] : (enq_vld ? enq_data : '0);
   assign count    = cnt_q;

   // An entry that bypasses straight out while empty never occupies storage.
   assign store = enq_vld & ~(empty & deq_rdy);
   assign pop   = deq_rdy & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_idx_q <= 1'b0;
         rd_idx_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (store) begin
            mem_q[wr_idx_q] <= enq_data;
            wr_idx_q        <= ~wr_idx_q;
         end
         if (pop) begin
            rd_idx_q <= ~rd_idx_q;
         end
         case ({store, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl
// Streams a kernel of num_bytes weights starting at base_addr out of
// weight_sram (one-cycle registered read) as 32-bit little-endian words on a
// valid/ready stream, and shares the SRAM port with host weight writes while
// idle.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; abandons any transfer (no done)
//   bus  weight_fetch_ctrl_if.slave: command (start/base_addr/num_bytes,
//        busy/done), host write port, SRAM port, output stream
// -----------------------------------------------------------------------------
module weight_fetch_ctrl
   import weight_fetch_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 17
) (
   input  logic                clk,
   input  logic                rst,
   weight_fetch_ctrl_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_FETCH = FETCH;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam int WCNT_W  = LEN_W - 1;
   localparam int ENTRY_W = DATA_W + 5;

   logic [1:0]         state_q;
   logic [ADDR_W-1:0]  rd_ptr_q;
   logic [WCNT_W-1:0]  issue_left_q;
   logic [3:0]         last_keep_q;
   logic               done_q;

   logic               rd_vld_p1;
   logic               rd_last_p1;
   logic [3:0]         rd_keep_p1;

   logic [LEN_W:0]     nb_round;
   logic [WCNT_W-1:0]  start_words;
   logic [1:0]         fifo_cnt;
   logic               credit_ok;
   logic               issue;
   logic               final_issue;
   logic [ENTRY_W-1:0] enq_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic               head_vld;
   logic               out_fire;

   assign nb_round    = {1'b0, bus.num_bytes} + (LEN_W+1)'(BYTES_PER_WORD - 1);
   assign start_words = WCNT_W'(nb_round >> 2);

   // The read returning this cycle plus the stored entries may not exceed the
   // two buffer slots, so a full buffer never sees another enqueue.
   assign credit_ok   = (2'(rd_vld_p1) + fifo_cnt) < 2'd2;
   assign issue       = (state_q == ST_FETCH) && (issue_left_q != '0) && credit_ok;
   assign final_issue = issue && (issue_left_q == WCNT_W'(1));

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.host_ready = (state_q == ST_IDLE);
   assign bus.done       = done_q;

   // SRAM port: host owns it while idle, the read pointer owns it otherwise.
   always_comb begin
      bus.sram_wen  = 1'b0;
      bus.sram_addr = '0;
      bus.sram_d    = '0;
      if (state_q == ST_IDLE) begin
         if (!rst) begin
            bus.sram_wen  = bus.host_wen;
            bus.sram_addr = bus.host_addr;
            bus.sram_d    = bus.host_d;
         end
      end else begin
         bus.sram_addr = rd_ptr_q;
      end
   end

   // ---- stage p0 -> p1: read issued, sidebands travel with the SRAM latency ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rd_ptr_q     <= '0;
         issue_left_q <= '0;
         last_keep_q  <= 4'h0;
         done_q       <= 1'b0;
         rd_vld_p1    <= 1'b0;
         rd_last_p1   <= 1'b0;
         rd_keep_p1   <= 4'h0;
      end else begin
         done_q    <= 1'b0;
         rd_vld_p1 <= issue;
         if (issue) begin
            rd_last_p1   <= final_issue;
            rd_keep_p1   <= final_issue ? last_keep_q : 4'hF;
            rd_ptr_q     <= rd_ptr_q + ADDR_W'(BYTES_PER_WORD);
            issue_left_q <= issue_left_q - WCNT_W'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.num_bytes == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q      <= ST_FETCH;
                     rd_ptr_q     <= bus.base_addr;
                     issue_left_q <= start_words;
                     last_keep_q  <= keep_mask(bus.num_bytes[1:0]);
                  end
               end
            end
            ST_FETCH: begin
               if (final_issue) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_fire && bus.out_last) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ---- stage p1: read data captured into the skid buffer ----
   assign enq_entry = {rd_last_p1, rd_keep_p1, bus.sram_q};

   weight_skid_fifo #(.WIDTH(ENTRY_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .enq_vld  (rd_vld_p1),
      .enq_data (enq_entry),
      .deq_vld  (head_vld),
      .deq_data (head_entry),
      .deq_rdy  (bus.out_ready),
      .count    (fifo_cnt)
   );

   assign out_fire      = head_vld & bus.out_ready;
   assign bus.out_valid = head_vld;
   assign bus.out_data  = head_entry[DATA_W-1:0];
   assign bus.out_keep  = head_entry[DATA_W+3:DATA_W];
   assign bus.out_last  = head_entry[ENTRY_W-1];
endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
Sequencer in front of weight_sram (byte-addressed, 32-bit little-endian read word, one-cycle registered read latency). On a start command it streams a kernel of num_bytes weights from base_addr to the FFT convolution datapath as 32-bit words with a valid/ready handshake. A 2-entry buffer absorbs read latency under backpressure. It also arbitrates the SRAM port between fetch and host/testbench weight writes.

Parameters:
ADDR_W, 16, SRAM byte address width
DATA_W, 32, SRAM word width (4 bytes)
LEN_W, 17, width of num_bytes (covers a full 64 KiB)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle fetch request; sampled only in IDLE
base_addr  in  ADDR_W  byte address of first weight
num_bytes  in  LEN_W  kernel size in bytes (kernel_H*kernel_W)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last word is accepted downstream
host_wen  in  1  host write request
host_addr  in  ADDR_W  host write address
host_d  in  DATA_W  host write data
host_ready  out  1  equals ~busy; a host write is accepted when host_wen & host_ready
sram_wen  out  1  to weight_sram wen
sram_addr  out  ADDR_W  to weight_sram addr
sram_d  out  DATA_W  to weight_sram d
sram_q  in  DATA_W  from weight_sram q
out_valid  out  1  word available
out_ready  in  1  downstream accepts
out_data  out  DATA_W  weight word; byte0 = lowest address
out_keep  out  4  valid-byte mask; 4'hF except on a partial last word
out_last  out  1  marks the final word

Behaviour:
- Reset (async): FSM=IDLE; busy, done, out_valid, out_last, sram_wen = 0; out_keep = 0; sram_addr, sram_d, out_data = 0; counters and buffer cleared. Reset mid-fetch abandons the transfer with no done pulse.
- Words = ceil(num_bytes/4). Last-word keep = 4'hF if num_bytes%4==0, else (1<<(num_bytes%4))-1.
- FSM states:
  - IDLE: host_ready=1; sram_wen/addr/d = host_wen/host_addr/host_d combinationally.
    - start with num_bytes==0: next cycle done=1 for one cycle; busy stays 0; no output.
    - start otherwise: latch base_addr and word count; go to FETCH; busy=1 from the next cycle.
    - start and host_wen in the same cycle: the write is performed and the fetch accepted.
  - FETCH:
    - Issues a read (sram_wen=0, sram_addr=rd_ptr) in any cycle where reads_issued < words and (in_flight + buffered) < 2.
    - rd_ptr advances by 4 per issue, modulo 2^ADDR_W (wrap from 16'hFFFC to 16'h0000).
    - After the final issue, go to DRAIN.
  - DRAIN: wait until the final word is accepted (out_valid & out_ready & out_last). Then pulse done, clear busy, return to IDLE in the same edge.
- Read latency: a read issued at cycle t captures sram_q into the buffer at t+1. out_valid is asserted from t+1 (buffer head is visible in the cycle of capture via bypass).
- Buffer: 2 entries {data, keep, last}. Enqueue on read return; dequeue on out_valid & out_ready. Simultaneous enqueue+dequeue is legal when full. The credit rule guarantees no overflow.
- Streaming: with out_ready held high, one word per cycle after a 1-cycle startup. A 4-word kernel shows out_valid in cycles 1..4 after the FETCH entry, and done in cycle 5.
- out_data, out_keep and out_last hold stable while out_valid & ~out_ready.
- During busy, host_wen is ignored (host_ready=0) and sram_wen=0.
- start during busy is ignored.

Decomposition:
- Package weight_fetch_pkg holds:
  - FSM state enum {IDLE, FETCH, DRAIN}
  - BYTES_PER_WORD=4
  - the keep-mask function
- One sub-module, weight_skid_fifo: 2-entry synchronous FIFO with bypass. It reports count to the credit logic.

Test Plan:
- Preload bytes 0..8 = 1..9; start, base 0, num_bytes 9, out_ready=1 -> words 0x04030201, 0x08070605, 0x00000009 (upper bytes don't-care); keeps F, F, 1; last on the third word; done one cycle after.
- Same fetch with out_ready toggling 1,0,0,1,... -> identical word order, no loss or duplication, and at most 2 reads outstanding+buffered at any cycle.
- num_bytes=0 -> done pulses next cycle; busy and out_valid never assert.
- base 16'hFFFC, num_bytes 8 -> reads at FFFC then 0000; out_keep F, F.
- host_wen during busy -> host_ready=0 and SRAM unchanged. The same write in IDLE, followed by a fetch of that address, returns the written data.
- Assert rst mid-fetch after 2 words -> all outputs 0 immediately; no done. A new start after reset fetches correctly.
